// File: rtl/bus_scheduler_if.sv
// Bus scheduler interface: groups the requester inputs and the scheduled bus
// outputs. The master modport is the scheduler; the slave modport is the
// requester/bus side that drives requests and observes the bus.
interface bus_scheduler_if #(
    parameter int ADDR_WIDTH = 17
);
    // CPU requester
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic                  cpu_rw_b;
    logic                  cpu_halt;
    // Video fetch requester
    logic [ADDR_WIDTH-1:0] video_addr;
    // SPI bridge requester
    logic                  spi_req;
    logic [ADDR_WIDTH-1:0] spi_addr;
    logic                  spi_rw_b;
    // Scheduled bus and completion signals
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic                  bus_rw_b;
    logic                  bus_strobe;
    logic [1:0]            bus_owner;
    logic                  cpu_clk_en;
    logic                  video_load;
    logic                  spi_busy;
    logic                  spi_ack;

    modport master (
        input  cpu_addr, cpu_rw_b, cpu_halt, video_addr,
        input  spi_req, spi_addr, spi_rw_b,
        output bus_addr, bus_rw_b, bus_strobe, bus_owner,
        output cpu_clk_en, video_load, spi_busy, spi_ack
    );

    modport slave (
        output cpu_addr, cpu_rw_b, cpu_halt, video_addr,
        output spi_req, spi_addr, spi_rw_b,
        input  bus_addr, bus_rw_b, bus_strobe, bus_owner,
        input  cpu_clk_en, video_load, spi_busy, spi_ack
    );
endinterface

// File: rtl/bus_scheduler.sv
// Time-slot scheduler for the shared system bus. A frame is three fixed
// slots (CPU, VIDEO, SPI) of SLOT_CYCLES clocks each. The slot owner is
// captured at cycle 0 and held for the whole slot; the strobe covers the
// middle cycles (the decoder registers its select one clock after the
// address) and the owner's completion pulse fires in the last cycle.
module bus_scheduler #(
    parameter int SLOT_CYCLES = 4,
    parameter int ADDR_WIDTH  = 17
) (
    input  logic           clk,
    input  logic           reset,
    bus_scheduler_if.master bus
);
    localparam int CW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 2;
    localparam logic [CW-1:0] CYC_FIRST    = CW'(0);
    localparam logic [CW-1:0] CYC_ONE      = CW'(1);
    localparam logic [CW-1:0] CYC_STB_LAST = CW'(SLOT_CYCLES - 2);
    localparam logic [CW-1:0] CYC_LAST     = CW'(SLOT_CYCLES - 1);

    localparam logic [1:0] OWN_IDLE  = 2'd0;
    localparam logic [1:0] OWN_CPU   = 2'd1;
    localparam logic [1:0] OWN_VIDEO = 2'd2;
    localparam logic [1:0] OWN_SPI   = 2'd3;

    typedef enum logic [1:0] {
        SLOT_CPU   = 2'd0,
        SLOT_VIDEO = 2'd1,
        SLOT_SPI   = 2'd2
    } slot_e;

    // slot_r/cyc_r name the position of the cycle that the next clock edge
    // enters; the output registers are loaded for that position so they are
    // valid during the cycle itself.
    slot_e                 slot_r;
    slot_e                 slot_nxt_s;
    logic [CW-1:0]         cyc_r;
    logic [CW-1:0]         cyc_nxt_s;

    logic                  spi_pending_r;
    logic [ADDR_WIDTH-1:0] spi_addr_r;
    logic                  spi_rw_b_r;
    logic                  spi_accept_s;
    logic                  spi_pending_nxt_s;
    logic                  spi_pending_now_s;
    logic [ADDR_WIDTH-1:0] spi_addr_now_s;
    logic                  spi_rw_b_now_s;

    logic [ADDR_WIDTH-1:0] bus_addr_r;
    logic [ADDR_WIDTH-1:0] bus_addr_nxt_s;
    logic                  bus_rw_b_r;
    logic                  bus_rw_b_nxt_s;
    logic [1:0]            bus_owner_r;
    logic [1:0]            bus_owner_nxt_s;
    logic                  bus_strobe_r;
    logic                  bus_strobe_nxt_s;
    logic                  cpu_clk_en_r;
    logic                  cpu_clk_en_nxt_s;
    logic                  video_load_r;
    logic                  video_load_nxt_s;
    logic                  spi_ack_r;
    logic                  spi_ack_nxt_s;
    logic                  last_cyc_s;

    // Slot/cycle state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_r <= SLOT_CPU;
            cyc_r  <= CYC_FIRST;
        end else begin
            slot_r <= slot_nxt_s;
            cyc_r  <= cyc_nxt_s;
        end
    end

    // Next slot/cycle: count through the slot, then step CPU -> VIDEO -> SPI.
    always_comb begin
        slot_nxt_s = slot_r;
        cyc_nxt_s  = cyc_r + CYC_ONE;
        if (cyc_r == CYC_LAST) begin
            cyc_nxt_s = CYC_FIRST;
            case (slot_r)
                SLOT_CPU:   slot_nxt_s = SLOT_VIDEO;
                SLOT_VIDEO: slot_nxt_s = SLOT_SPI;
                SLOT_SPI:   slot_nxt_s = SLOT_CPU;
                default:    slot_nxt_s = SLOT_CPU;
            endcase
        end else begin
            slot_nxt_s = slot_r;
        end
    end

    // SPI request acceptance; a request arriving on the SPI capture edge is
    // served in that slot, which keeps the worst case at 4*SLOT_CYCLES-1.
    always_comb begin
        spi_accept_s      = bus.spi_req & ~spi_pending_r;
        spi_pending_now_s = spi_pending_r | spi_accept_s;
        spi_pending_nxt_s = (spi_pending_r & ~spi_ack_r) | spi_accept_s;
        if (spi_accept_s) begin
            spi_addr_now_s = bus.spi_addr;
            spi_rw_b_now_s = bus.spi_rw_b;
        end else begin
            spi_addr_now_s = spi_addr_r;
            spi_rw_b_now_s = spi_rw_b_r;
        end
    end

    // SPI pending flag and latched request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spi_pending_r <= 1'b0;
            spi_addr_r    <= '0;
            spi_rw_b_r    <= 1'b1;
        end else begin
            spi_pending_r <= spi_pending_nxt_s;
            spi_addr_r    <= spi_addr_now_s;
            spi_rw_b_r    <= spi_rw_b_now_s;
        end
    end

    // Owner capture at cycle 0, strobe for the middle cycles, completion
    // pulse for the slot owner in the last cycle.
    always_comb begin
        bus_addr_nxt_s  = bus_addr_r;
        bus_rw_b_nxt_s  = bus_rw_b_r;
        bus_owner_nxt_s = bus_owner_r;
        last_cyc_s      = (cyc_r == CYC_LAST);
        if (cyc_r == CYC_FIRST) begin
            case (slot_r)
                SLOT_CPU: begin
                    if (!bus.cpu_halt) begin
                        bus_addr_nxt_s  = bus.cpu_addr;
                        bus_rw_b_nxt_s  = bus.cpu_rw_b;
                        bus_owner_nxt_s = OWN_CPU;
                    end else begin
                        bus_rw_b_nxt_s  = 1'b1;
                        bus_owner_nxt_s = OWN_IDLE;
                    end
                end
                SLOT_VIDEO: begin
                    bus_addr_nxt_s  = bus.video_addr;
                    bus_rw_b_nxt_s  = 1'b1;
                    bus_owner_nxt_s = OWN_VIDEO;
                end
                SLOT_SPI: begin
                    if (spi_pending_now_s) begin
                        bus_addr_nxt_s  = spi_addr_now_s;
                        bus_rw_b_nxt_s  = spi_rw_b_now_s;
                        bus_owner_nxt_s = OWN_SPI;
                    end else begin
                        bus_rw_b_nxt_s  = 1'b1;
                        bus_owner_nxt_s = OWN_IDLE;
                    end
                end
                default: begin
                    bus_rw_b_nxt_s  = 1'b1;
                    bus_owner_nxt_s = OWN_IDLE;
                end
            endcase
        end else begin
            bus_owner_nxt_s = bus_owner_r;
        end
        bus_strobe_nxt_s = (cyc_r != CYC_FIRST) && (cyc_r <= CYC_STB_LAST) &&
                           (bus_owner_r != OWN_IDLE);
        cpu_clk_en_nxt_s = last_cyc_s && (bus_owner_r == OWN_CPU);
        video_load_nxt_s = last_cyc_s && (bus_owner_r == OWN_VIDEO);
        spi_ack_nxt_s    = last_cyc_s && (bus_owner_r == OWN_SPI);
    end

    // Registered bus and pulse outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_addr_r   <= '0;
            bus_rw_b_r   <= 1'b1;
            bus_owner_r  <= OWN_IDLE;
            bus_strobe_r <= 1'b0;
            cpu_clk_en_r <= 1'b0;
            video_load_r <= 1'b0;
            spi_ack_r    <= 1'b0;
        end else begin
            bus_addr_r   <= bus_addr_nxt_s;
            bus_rw_b_r   <= bus_rw_b_nxt_s;
            bus_owner_r  <= bus_owner_nxt_s;
            bus_strobe_r <= bus_strobe_nxt_s;
            cpu_clk_en_r <= cpu_clk_en_nxt_s;
            video_load_r <= video_load_nxt_s;
            spi_ack_r    <= spi_ack_nxt_s;
        end
    end

    assign bus.bus_addr   = bus_addr_r;
    assign bus.bus_rw_b   = bus_rw_b_r;
    assign bus.bus_owner  = bus_owner_r;
    assign bus.bus_strobe = bus_strobe_r;
    assign bus.cpu_clk_en = cpu_clk_en_r;
    assign bus.video_load = video_load_r;
    assign bus.spi_ack    = spi_ack_r;
    assign bus.spi_busy   = spi_pending_r;
endmodule

// File: tb/tb_bus_scheduler.sv
// Directed testbench for bus_scheduler (SLOT_CYCLES = 4). Clock k is the
// cycle entered by the k-th rising edge after reset release; outputs are
// sampled 1 time unit after that edge, and inputs driven at that point are
// sampled by edge k+1.
module tb_bus_scheduler;
    localparam int AW = 17;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   chk_cnt = 0;
    int   err_cnt = 0;

    bus_scheduler_if #(.ADDR_WIDTH(AW)) bif ();

    bus_scheduler #(.SLOT_CYCLES(4), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        bif.cpu_addr   = 17'h0_1234;
        bif.cpu_rw_b   = 1'b0;
        bif.cpu_halt   = 1'b0;
        bif.video_addr = 17'h0_8040;
        bif.spi_req    = 1'b0;
        bif.spi_addr   = 17'h0_0000;
        bif.spi_rw_b   = 1'b1;
    endtask

    task automatic next_clk();
        @(posedge clk);
        #1;
    endtask

    // Assert reset, release it on a falling edge, and land on clock 0.
    task automatic start_run();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        next_clk();
    endtask

    task automatic check_reset_values(input string tag);
        check_value({tag, " owner"},  32'(bif.bus_owner),  32'd0);
        check_value({tag, " addr"},   32'(bif.bus_addr),   32'd0);
        check_value({tag, " rw_b"},   32'(bif.bus_rw_b),   32'd1);
        check_value({tag, " strobe"}, 32'(bif.bus_strobe), 32'd0);
        check_value({tag, " busy"},   32'(bif.spi_busy),   32'd0);
        check_value({tag, " ack"},    32'(bif.spi_ack),    32'd0);
        check_value({tag, " clk_en"}, 32'(bif.cpu_clk_en), 32'd0);
        check_value({tag, " vload"},  32'(bif.video_load), 32'd0);
    endtask

    initial begin
        int          pos;
        int          c;
        logic [1:0]  exp_owner;
        logic [16:0] exp_addr;
        logic        exp_rw;

        // Reset state
        set_idle();
        @(posedge clk);
        #1;
        check_reset_values("rst");

        // Frame timing and address mux, no halt, no SPI
        start_run();
        for (int k = 0; k <= 27; k++) begin
            if (k > 0) next_clk();
            pos = k % 12;
            c   = k % 4;
            exp_owner = (pos < 4) ? 2'd1 : ((pos < 8) ? 2'd2 : 2'd0);
            exp_addr  = (pos < 4) ? ((k < 12) ? 17'h0_1234 : 17'h0_5555) : 17'h0_8040;
            exp_rw    = (pos < 4) ? 1'b0 : 1'b1;
            check_value($sformatf("timing owner @%0d", k), 32'(bif.bus_owner), 32'(exp_owner));
            check_value($sformatf("timing addr @%0d", k), 32'(bif.bus_addr), 32'(exp_addr));
            check_value($sformatf("timing rw_b @%0d", k), 32'(bif.bus_rw_b), 32'(exp_rw));
            check_value($sformatf("timing strobe @%0d", k), 32'(bif.bus_strobe),
                        32'((c == 1 || c == 2) && exp_owner != 2'd0));
            check_value($sformatf("timing clk_en @%0d", k), 32'(bif.cpu_clk_en),
                        32'(k == 3 || k == 15 || k == 27));
            check_value($sformatf("timing vload @%0d", k), 32'(bif.video_load),
                        32'(k == 7 || k == 19));
            check_value($sformatf("timing busy @%0d", k), 32'(bif.spi_busy), 32'd0);
            // Mid-slot CPU address change must not disturb the held bus address
            if (k == 1) bif.cpu_addr = 17'h0_5555;
        end

        // SPI early request, plus an ignored second request
        set_idle();
        start_run();
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) next_clk();
            check_value($sformatf("spi_early busy @%0d", k), 32'(bif.spi_busy),
                        32'(k >= 3 && k <= 11));
            check_value($sformatf("spi_early ack @%0d", k), 32'(bif.spi_ack), 32'(k == 11));
            if (k >= 8 && k <= 11) begin
                check_value($sformatf("spi_early owner @%0d", k), 32'(bif.bus_owner), 32'd3);
                check_value($sformatf("spi_early addr @%0d", k), 32'(bif.bus_addr), 32'h1_E810);
                check_value($sformatf("spi_early rw_b @%0d", k), 32'(bif.bus_rw_b), 32'd1);
                check_value($sformatf("spi_early strobe @%0d", k), 32'(bif.bus_strobe),
                            32'(k == 9 || k == 10));
            end
            if (k == 2) begin
                bif.spi_req  = 1'b1;
                bif.spi_addr = 17'h1_E810;
                bif.spi_rw_b = 1'b1;
            end else if (k == 5) begin
                bif.spi_req  = 1'b1;
                bif.spi_addr = 17'h0_0AAA;
                bif.spi_rw_b = 1'b0;
            end else begin
                bif.spi_req  = 1'b0;
            end
        end

        // SPI late request: waits a whole frame; request on ack is ignored
        set_idle();
        start_run();
        for (int k = 0; k <= 32; k++) begin
            if (k > 0) next_clk();
            check_value($sformatf("spi_late busy @%0d", k), 32'(bif.spi_busy),
                        32'(k >= 9 && k <= 23));
            check_value($sformatf("spi_late ack @%0d", k), 32'(bif.spi_ack), 32'(k == 23));
            if ((k >= 8 && k <= 11) || k == 32) begin
                check_value($sformatf("spi_late idle owner @%0d", k), 32'(bif.bus_owner), 32'd0);
                check_value($sformatf("spi_late idle rw_b @%0d", k), 32'(bif.bus_rw_b), 32'd1);
            end
            if (k >= 20 && k <= 23) begin
                check_value($sformatf("spi_late owner @%0d", k), 32'(bif.bus_owner), 32'd3);
                check_value($sformatf("spi_late addr @%0d", k), 32'(bif.bus_addr), 32'h0_0C0C);
                check_value($sformatf("spi_late rw_b @%0d", k), 32'(bif.bus_rw_b), 32'd0);
                check_value($sformatf("spi_late strobe @%0d", k), 32'(bif.bus_strobe),
                            32'(k == 21 || k == 22));
            end
            if (k == 8) begin
                bif.spi_req  = 1'b1;
                bif.spi_addr = 17'h0_0C0C;
                bif.spi_rw_b = 1'b0;
            end else if (k == 23) begin
                bif.spi_req  = 1'b1;
                bif.spi_addr = 17'h1_FFFF;
                bif.spi_rw_b = 1'b1;
            end else begin
                bif.spi_req  = 1'b0;
            end
        end

        // CPU halt sampled at the frame-2 CPU capture edge only
        set_idle();
        start_run();
        for (int k = 0; k <= 27; k++) begin
            if (k > 0) next_clk();
            check_value($sformatf("halt clk_en @%0d", k), 32'(bif.cpu_clk_en),
                        32'(k == 3 || k == 27));
            if (k >= 12 && k <= 15) begin
                check_value($sformatf("halt owner @%0d", k), 32'(bif.bus_owner), 32'd0);
                check_value($sformatf("halt strobe @%0d", k), 32'(bif.bus_strobe), 32'd0);
                check_value($sformatf("halt addr @%0d", k), 32'(bif.bus_addr), 32'h0_8040);
                check_value($sformatf("halt rw_b @%0d", k), 32'(bif.bus_rw_b), 32'd1);
            end
            if (k >= 24) begin
                check_value($sformatf("halt resume owner @%0d", k), 32'(bif.bus_owner), 32'd1);
            end
            if (k == 11) bif.cpu_halt = 1'b1;
            else if (k == 12) bif.cpu_halt = 1'b0;
        end

        // Reset during a pending SPI write in its own slot
        set_idle();
        start_run();
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) next_clk();
            if (k == 2) begin
                bif.spi_req  = 1'b1;
                bif.spi_addr = 17'h0_4321;
                bif.spi_rw_b = 1'b0;
            end else begin
                bif.spi_req  = 1'b0;
            end
        end
        check_value("abort owner before reset", 32'(bif.bus_owner), 32'd3);
        check_value("abort addr before reset", 32'(bif.bus_addr), 32'h0_4321);
        reset = 1'b1;
        #1;
        check_reset_values("abort immediate");
        for (int i = 0; i < 3; i++) begin
            next_clk();
            check_value($sformatf("abort hold ack %0d", i), 32'(bif.spi_ack), 32'd0);
            check_value($sformatf("abort hold owner %0d", i), 32'(bif.bus_owner), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k <= 11; k++) begin
            next_clk();
            check_value($sformatf("after abort busy @%0d", k), 32'(bif.spi_busy), 32'd0);
            check_value($sformatf("after abort ack @%0d", k), 32'(bif.spi_ack), 32'd0);
            if (k == 0) begin
                check_value("after abort owner @0", 32'(bif.bus_owner), 32'd1);
                check_value("after abort addr @0", 32'(bif.bus_addr), 32'h0_1234);
            end
            if (k == 8) begin
                check_value("after abort spi owner @8", 32'(bif.bus_owner), 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end
endmodule
